// File: rtl/serial_add_arb.sv
// -----------------------------------------------------------------------------
// serial_add_arb
//   Two requesters share one bit-serial adder built from a single 1-bit full
//   adder. A round-robin arbiter picks a requester in IDLE. The adder then
//   produces one result bit per cycle, LSB first, over WIDTH cycles. DONE
//   presents the result for one cycle.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   req0/req1      level requests, held until the matching grant
//   a0,b0,cin0     requester 0 operands and carry-in
//   a1,b1,cin1     requester 1 operands and carry-in
//   gnt0/gnt1      one-cycle accept pulse (first ADD cycle)
//   busy           controller not in IDLE
//   done           one-cycle result-valid pulse
//   done_id        requester owning the presented result
//   sum, cout      result and carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_id;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_cout;
  logic             r_done_id;

  logic             w_req_any;
  logic             w_win1;
  logic             w_last_bit;
  logic             w_sum_bit;
  logic             w_carry_bit;

  assign w_req_any  = req0 | req1;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_win1     = req1 & (~req0 | ~r_last);
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  // The one shared full adder. The operand registers shift right, so the
  // current bit is always at position 0.
  assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_bit = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req_any)  w_state_next = ST_ADD;
      ST_ADD:  if (w_last_bit) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_cout    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_a     <= w_win1 ? a1 : a0;
            r_b     <= w_win1 ? b1 : b0;
            r_carry <= w_win1 ? cin1 : cin0;
            r_id    <= w_win1;
            r_last  <= w_win1;
            r_cnt   <= '0;
            r_gnt0  <= ~w_win1;
            r_gnt1  <= w_win1;
          end
        end
        ST_ADD: begin
          r_sum[r_cnt] <= w_sum_bit;
          r_carry      <= w_carry_bit;
          r_a          <= r_a >> 1;
          r_b          <= r_b >> 1;
          r_cnt        <= r_cnt + CW'(1);
          // cout and done_id change only when a result completes, so they
          // keep the previous result through the next operation's ADD phase.
          if (w_last_bit) begin
            r_cout    <= w_carry_bit;
            r_done_id <= r_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign done_id = r_done_id;
  assign sum     = r_sum;
  assign cout    = r_cout;

endmodule

// File: tb/tb_serial_add_arb.sv
// -----------------------------------------------------------------------------
// tb_serial_add_arb
//   Directed and random checks of serial_add_arb at WIDTH=8. Each scenario
//   task drives stimulus and compares the outputs against values worked out
//   by hand. The random scenario uses a small arbitration/adder model.
// -----------------------------------------------------------------------------
module tb_serial_add_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, done_id, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for done. cyc counts ticks from the call.
  task automatic wait_done(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; a0 = 8'h11; b0 = 8'h22; a1 = 8'h33; b1 = 8'h44;
    rst = 1'b1;
    tick();
    tick();
    n_cmp += 7;
    if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (gnt0 !== 1'b0)    begin n_err++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    if (gnt1 !== 1'b0)    begin n_err++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
    if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    if (done_id !== 1'b0) begin n_err++; $display("FAIL reset_done_id got=%b exp=0", done_id); end
    if (sum !== 8'h00)    begin n_err++; $display("FAIL reset_sum got=%h exp=00", sum); end
    if (cout !== 1'b0)    begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    $display("reset: busy=%b sum=%h cout=%b", busy, sum, cout);
  endtask

  // Requester 1 alone, with last-served still at its reset value of 1.
  task automatic test_single1();
    bit ok; int cyc;
    req1 = 1'b1; a1 = 8'h12; b1 = 8'h34; cin1 = 1'b1;
    tick();
    n_cmp += 3;
    if (gnt1 !== 1'b1) begin n_err++; $display("FAIL s1_gnt1 got=%b exp=1", gnt1); end
    if (gnt0 !== 1'b0) begin n_err++; $display("FAIL s1_gnt0 got=%b exp=0", gnt0); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL s1_busy got=%b exp=1", busy); end
    req1 = 1'b0; a1 = 8'hEE; b1 = 8'hEE; cin1 = 1'b0;
    wait_done(ok, cyc);
    n_cmp += 4;
    if (!ok || cyc != 8) begin n_err++; $display("FAIL s1_latency got=%0d exp=8 (ok=%0d)", cyc, ok); end
    if (sum !== 8'h47)    begin n_err++; $display("FAIL s1_sum got=%h exp=47", sum); end
    if (cout !== 1'b0)    begin n_err++; $display("FAIL s1_cout got=%b exp=0", cout); end
    if (done_id !== 1'b1) begin n_err++; $display("FAIL s1_done_id got=%b exp=1", done_id); end
    tick();
    $display("single1: sum=%h cout=%b id=%b lat=%0d", sum, cout, done_id, cyc + 1);
  endtask

  task automatic test_single0();
    bit ok; int cyc;
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'h01; cin0 = 1'b0;
    tick();
    n_cmp += 2;
    if (gnt0 !== 1'b1) begin n_err++; $display("FAIL s0_gnt0 got=%b exp=1", gnt0); end
    if (gnt1 !== 1'b0) begin n_err++; $display("FAIL s0_gnt1 got=%b exp=0", gnt1); end
    // Operand changes after capture must not affect the result.
    req0 = 1'b0; a0 = 8'h5A; b0 = 8'hA5; cin0 = 1'b1;
    tick();
    n_cmp += 1;
    if (gnt0 !== 1'b0) begin n_err++; $display("FAIL s0_gnt_pulse got=%b exp=0", gnt0); end
    wait_done(ok, cyc);
    n_cmp += 4;
    if (!ok || cyc != 7) begin n_err++; $display("FAIL s0_latency got=%0d exp=7 (ok=%0d)", cyc, ok); end
    if (sum !== 8'h00)    begin n_err++; $display("FAIL s0_sum got=%h exp=00", sum); end
    if (cout !== 1'b1)    begin n_err++; $display("FAIL s0_cout got=%b exp=1", cout); end
    if (done_id !== 1'b0) begin n_err++; $display("FAIL s0_done_id got=%b exp=0", done_id); end
    tick();
    n_cmp += 4;
    if (done !== 1'b0)    begin n_err++; $display("FAIL s0_done_pulse got=%b exp=0", done); end
    if (busy !== 1'b0)    begin n_err++; $display("FAIL s0_idle got=%b exp=0", busy); end
    if (sum !== 8'h00)    begin n_err++; $display("FAIL s0_sum_hold got=%h exp=00", sum); end
    if (cout !== 1'b1)    begin n_err++; $display("FAIL s0_cout_hold got=%b exp=1", cout); end
    $display("single0: sum=%h cout=%b id=%b", sum, cout, done_id);
  endtask

  // Both requesters held: grants alternate 0,1,0,1 every 10 cycles.
  task automatic test_round_robin();
    int       g_c[4], g_id[4], d_c[4], d_id[4];
    logic [8:0] d_res[4];
    int       ng, nd, both;
    logic [8:0] exp_res;
    ng = 0; nd = 0; both = 0;
    a0 = 8'h80; b0 = 8'h80; cin0 = 1'b1;
    a1 = 8'h0F; b1 = 8'hF0; cin1 = 1'b0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (gnt0 && gnt1) both++;
      if ((gnt0 || gnt1) && ng < 4) begin g_c[ng] = c; g_id[ng] = gnt1 ? 1 : 0; ng++; end
      if (done && nd < 4) begin d_c[nd] = c; d_id[nd] = int'(done_id); d_res[nd] = {cout, sum}; nd++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp += 3;
    if (both != 0) begin n_err++; $display("FAIL rr_both_gnt got=%0d exp=0", both); end
    if (ng != 4)   begin n_err++; $display("FAIL rr_gnt_count got=%0d exp=4", ng); end
    if (nd != 4)   begin n_err++; $display("FAIL rr_done_count got=%0d exp=4", nd); end
    for (int k = 0; k < ng; k++) begin
      n_cmp += 2;
      if (g_id[k] != k % 2)      begin n_err++; $display("FAIL rr_gnt_id[%0d] got=%0d exp=%0d", k, g_id[k], k % 2); end
      if (g_c[k] != 1 + 10 * k)  begin n_err++; $display("FAIL rr_gnt_cycle[%0d] got=%0d exp=%0d", k, g_c[k], 1 + 10 * k); end
    end
    for (int k = 0; k < nd; k++) begin
      exp_res = (k % 2 == 0) ? 9'h101 : 9'h0FF;
      n_cmp += 3;
      if (d_id[k] != k % 2)     begin n_err++; $display("FAIL rr_done_id[%0d] got=%0d exp=%0d", k, d_id[k], k % 2); end
      if (d_c[k] != 9 + 10 * k) begin n_err++; $display("FAIL rr_done_cycle[%0d] got=%0d exp=%0d", k, d_c[k], 9 + 10 * k); end
      if (d_res[k] !== exp_res) begin n_err++; $display("FAIL rr_result[%0d] got=%h exp=%h", k, d_res[k], exp_res); end
    end
    $display("round_robin: grants=%0d dones=%0d", ng, nd);
    tick();
    tick();
  endtask

  // Reset in the middle of ADD aborts; a later request still works.
  task automatic test_abort();
    bit ok; int cyc, nd;
    do_reset();
    req0 = 1'b1; a0 = 8'h55; b0 = 8'h0A; cin0 = 1'b0;
    tick();
    req0 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp += 4;
    if (busy !== 1'b0)  begin n_err++; $display("FAIL ab_busy got=%b exp=0", busy); end
    if (done !== 1'b0)  begin n_err++; $display("FAIL ab_done got=%b exp=0", done); end
    if (sum !== 8'h00)  begin n_err++; $display("FAIL ab_sum got=%h exp=00", sum); end
    if (cout !== 1'b0)  begin n_err++; $display("FAIL ab_cout got=%b exp=0", cout); end
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) nd++;
    end
    n_cmp += 1;
    if (nd != 0) begin n_err++; $display("FAIL ab_no_done got=%0d exp=0", nd); end
    req0 = 1'b1; cin0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_done(ok, cyc);
    n_cmp += 2;
    if (!ok || {cout, sum} !== 9'h060) begin n_err++; $display("FAIL ab_after got=%h exp=060 (ok=%0d)", {cout, sum}, ok); end
    if (done_id !== 1'b0)              begin n_err++; $display("FAIL ab_after_id got=%b exp=0", done_id); end
    tick();
    $display("abort: after-reset result=%h", {cout, sum});
  endtask

  // A request raised and dropped while busy is never granted.
  task automatic test_busy_request();
    int ng1, nd;
    logic [8:0] res;
    logic       rid;
    ng1 = 0; nd = 0; res = '0; rid = 1'b1;
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02; cin0 = 1'b0;
    tick();
    req0 = 1'b0;
    tick(); tick();
    req1 = 1'b1; a1 = 8'hAA; b1 = 8'hAA; cin1 = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) req1 = 1'b0;
      tick();
      if (gnt1) ng1++;
      if (done) begin nd++; res = {cout, sum}; rid = done_id; end
    end
    n_cmp += 5;
    if (ng1 != 0)       begin n_err++; $display("FAIL br_gnt1 got=%0d exp=0", ng1); end
    if (nd != 1)        begin n_err++; $display("FAIL br_done_count got=%0d exp=1", nd); end
    if (res !== 9'h003) begin n_err++; $display("FAIL br_result got=%h exp=003", res); end
    if (rid !== 1'b0)   begin n_err++; $display("FAIL br_done_id got=%b exp=0", rid); end
    if (busy !== 1'b0)  begin n_err++; $display("FAIL br_idle got=%b exp=0", busy); end
    $display("busy_request: gnt1=%0d dones=%0d result=%h", ng1, nd, res);
  endtask

  task automatic test_random();
    bit ok; int cyc, bad;
    int sel;
    logic last, win;
    logic [8:0] exp_res;
    do_reset();
    last = 1'b1;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      sel  = int'($urandom_range(1, 3));
      a0   = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
      a1   = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
      req0 = sel[0]; req1 = sel[1];
      win  = (sel == 3) ? ~last : sel[1];
      exp_res = win ? (9'(a1) + 9'(b1) + 9'(cin1)) : (9'(a0) + 9'(b0) + 9'(cin0));
      tick();
      n_cmp += 1;
      if ({gnt1, gnt0} !== (win ? 2'b10 : 2'b01)) begin
        n_err++; bad++;
        $display("FAIL rnd_gnt[%0d] got=%b exp=%b", n, {gnt1, gnt0}, win ? 2'b10 : 2'b01);
      end
      last = win;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      wait_done(ok, cyc);
      n_cmp += 2;
      if (!ok || {cout, sum} !== exp_res) begin
        n_err++; bad++;
        $display("FAIL rnd_result[%0d] got=%h exp=%h (ok=%0d)", n, {cout, sum}, exp_res, ok);
      end
      if (done_id !== win) begin
        n_err++; bad++;
        $display("FAIL rnd_done_id[%0d] got=%b exp=%b", n, done_id, win);
      end
      tick();
    end
    $display("random: 1000 operations, %0d bad", bad);
  endtask

  initial begin
    test_reset();
    test_single1();
    test_single0();
    test_round_robin();
    test_abort();
    test_busy_request();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request, level, held until gnt0.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands, stable while req0 high.
REQ-006 cin0  input  1  requester 0 carry-in.
REQ-007 req1, a1, b1, cin1  input  1/WIDTH/WIDTH/1  requester 1 equivalents of REQ-004..006.
REQ-008 gnt0, gnt1  output  1 each  one-cycle accept pulse to the winning requester.
REQ-009 busy  output  1  high whenever the controller is not in IDLE.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 done_id  output  1  requester owning the current result (0 or 1).
REQ-012 sum  output  WIDTH  result, a + b + cin modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 Single shared 1-bit full adder (sum = a^b^c, carry = majority(a,b,c)); all addition is bit-serial, LSB first, one bit per cycle.
REQ-015 States: IDLE, ADD, DONE; encoding is free.
REQ-016 IDLE: if req0 or req1 high at an edge, capture winner's a, b, cin into operand/carry registers, record winner id, clear bit counter, go to ADD; else stay IDLE.
REQ-017 Arbitration: round-robin; single requester always wins; on simultaneous requests, winner is the requester not served last; last-served register resets to 1 (requester 0 wins first tie).
REQ-018 gntN is high for exactly the one cycle following the capture edge (first ADD cycle); never both high.
REQ-019 ADD: each edge computes bit k = counter value, writes sum[k], updates carry register, increments counter; after bit WIDTH-1 (WIDTH edges in ADD), go to DONE.
REQ-020 DONE: done high for exactly one cycle; sum, cout, done_id valid in that cycle; next edge go to IDLE.
REQ-021 Latency: done asserted WIDTH+1 cycles after the capture edge; minimum request-to-request spacing WIDTH+2 cycles.
REQ-022 sum, cout, done_id hold their values after DONE until the next DONE or reset; sum partial bits may update during ADD but are only valid when done is high.
REQ-023 Requests arriving while busy are not captured and not granted; a still-pending request is arbitrated in the IDLE cycle after DONE.
REQ-024 Operand inputs are not sampled outside the capture edge; changes during ADD have no effect.
REQ-025 cin of the winner is the initial carry; cout equals carry register after bit WIDTH-1.

Reset
REQ-026 rst high at an edge forces IDLE, counter 0, last-served = 1, all operand/carry registers 0.
REQ-027 Outputs after reset: gnt0=0, gnt1=0, busy=0, done=0, done_id=0, sum=0, cout=0.
REQ-028 Reset mid-ADD or in DONE aborts the operation; no done pulse is produced for it.
REQ-029 rst takes priority over any simultaneous request.

Verification (WIDTH=8)
REQ-030 req0, a0=8'hFF, b0=8'h01, cin0=0 -> gnt0 one cycle after capture, done 9 cycles after capture, sum=8'h00, cout=1, done_id=0.
REQ-031 req1 only, a1=8'h12, b1=8'h34, cin1=1 -> gnt1, sum=8'h47, cout=0, done_id=1 (single requester wins regardless of last-served).
REQ-032 After reset, req0 and req1 both held continuously -> order of grants 0,1,0,1; results match each requester's operands; grants spaced 10 cycles.
REQ-033 Start op, assert rst after 4 ADD cycles -> next cycle busy=0, sum=0, cout=0, no done; a following request completes correctly.
REQ-034 Pulse req1 while busy and drop it before DONE -> no gnt1, no second operation.
REQ-035 1000 random operand/cin/requester sequences -> every done matches {cout,sum} = a+b+cin of the granted requester's captured operands.
